// File: rtl/qspi_flash_rd_slave.sv
// SPI-flash read emulation slave: decodes 03h/0Bh frames, requests line fills on
// line change and streams line-buffer RAM words MSB-first with in-line wrap.
module qspi_flash_rd_slave #(
  parameter int          ADDR_W    = 24,
  parameter int          RAM_DW    = 16,
  parameter int          LINE_AW   = 3,
  parameter int          DUMMY_CYC = 8,
  parameter logic [7:0]  CMD_READ  = 8'h03,
  parameter logic [7:0]  CMD_FAST  = 8'h0B
) (
  input  logic               qspi_clk,
  input  logic               rst_n,
  input  logic               qspi_csn,
  input  logic               qspi_di,
  output logic               qspi_do,
  output logic               qspi_do_oe,
  output logic [1:0]         cmd_flag,
  output logic [ADDR_W-1:0]  line_addr,
  output logic               line_req,
  input  logic               line_busy,
  output logic               ram_ren,
  output logic [LINE_AW-1:0] ram_raddr,
  input  logic [RAM_DW-1:0]  ram_rdata,
  output logic               rd_stale
);

  localparam int BYTE_AW = $clog2(RAM_DW / 8);
  localparam int SH_W    = ((ADDR_W > 8) ? ADDR_W : 8) - 1;
  localparam int MAX_CNT = ((SH_W + 1) > DUMMY_CYC) ? (SH_W + 1) : DUMMY_CYC;
  localparam int CNT_W   = $clog2(MAX_CNT);
  localparam int OL_W    = $clog2(RAM_DW + 1);
  localparam logic [ADDR_W-1:0] BYTE_MASK = ADDR_W'((64'd1 << BYTE_AW) - 64'd1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((64'd1 << (BYTE_AW + LINE_AW)) - 64'd1);

  typedef enum logic [2:0] {S_CMD, S_ADDR, S_DUMMY, S_DATA, S_IGNORE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt;
  logic [SH_W-1:0]    sh_in;
  logic [ADDR_W-1:0]  last_line;
  logic [OL_W-1:0]    load_shift;
  logic [OL_W-1:0]    out_left;
  logic [RAM_DW-1:0]  sh_out;
  logic               do_en;

  logic               cmd_done, addr_done, dummy_done;
  logic [7:0]         opcode;
  logic [ADDR_W-1:0]  addr_full, line_nxt;
  logic [LINE_AW-1:0] widx;
  logic [OL_W-1:0]    off_bits;

  // Opcode/address are taken from the shift register plus the bit on qspi_di,
  // so decode happens in the same edge as the final sample.
  always_comb begin
    opcode    = {sh_in[6:0], qspi_di};
    addr_full = {sh_in[ADDR_W-2:0], qspi_di};
    line_nxt  = addr_full & ~LINE_MASK;
    widx      = LINE_AW'(addr_full >> BYTE_AW);
    off_bits  = OL_W'((addr_full & BYTE_MASK) << 3);
  end

  always_ff @(posedge qspi_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_CMD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cmd_done   = 1'b0;
    addr_done  = 1'b0;
    dummy_done = 1'b0;
    if (qspi_csn) begin
      state_d = S_CMD;
    end else begin
      case (state_q)
        S_CMD: if (bit_cnt == CNT_W'(7)) begin
          cmd_done = 1'b1;
          state_d  = (opcode == CMD_READ || opcode == CMD_FAST) ? S_ADDR : S_IGNORE;
        end
        S_ADDR: if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
          addr_done = 1'b1;
          state_d   = cmd_flag[1] ? S_DUMMY : S_DATA;
        end
        S_DUMMY: if (bit_cnt == CNT_W'(DUMMY_CYC - 1)) begin
          dummy_done = 1'b1;
          state_d    = S_DATA;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge qspi_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      sh_in      <= '0;
      cmd_flag   <= '0;
      line_addr  <= '0;
      line_req   <= 1'b0;
      last_line  <= '1;
      ram_ren    <= 1'b0;
      ram_raddr  <= '0;
      load_shift <= '0;
      rd_stale   <= 1'b0;
    end else begin
      line_req <= 1'b0;
      ram_ren  <= 1'b0;
      if (qspi_csn) begin
        bit_cnt  <= '0;
        cmd_flag <= '0;
        sh_in    <= '0;
      end else begin
        sh_in <= {sh_in[SH_W-2:0], qspi_di};
        case (state_q)
          S_CMD: begin
            if (bit_cnt == '0) rd_stale <= 1'b0;
            if (cmd_done) begin
              bit_cnt <= '0;
              if (opcode == CMD_READ)      cmd_flag <= 2'b01;
              else if (opcode == CMD_FAST) cmd_flag <= 2'b10;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          S_ADDR: begin
            if (addr_done) begin
              bit_cnt    <= '0;
              line_addr  <= line_nxt;
              ram_raddr  <= widx;
              load_shift <= off_bits;
              ram_ren    <= ~cmd_flag[1];
              if (line_nxt != last_line) begin
                line_req  <= 1'b1;
                last_line <= line_nxt;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          S_DUMMY: begin
            if (dummy_done) begin
              bit_cnt <= '0;
              ram_ren <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          S_DATA: begin
            // Fetch the next word while the last bit of the current one is on the pin.
            if (out_left == OL_W'(1)) begin
              ram_ren    <= 1'b1;
              ram_raddr  <= ram_raddr + LINE_AW'(1);
              load_shift <= '0;
            end
          end
          default: ;
        endcase
      end
      if (ram_ren && line_busy) rd_stale <= 1'b1;
    end
  end

  always_ff @(negedge qspi_clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_out   <= '0;
      out_left <= '0;
      do_en    <= 1'b0;
    end else if (qspi_csn || state_q != S_DATA) begin
      sh_out   <= '0;
      out_left <= '0;
      do_en    <= 1'b0;
    end else if (ram_ren) begin
      sh_out   <= ram_rdata << load_shift;
      out_left <= OL_W'(RAM_DW) - load_shift;
      do_en    <= 1'b1;
    end else if (do_en) begin
      sh_out   <= {sh_out[RAM_DW-2:0], 1'b0};
      out_left <= out_left - OL_W'(1);
    end
  end

  assign qspi_do    = sh_out[RAM_DW-1];
  assign qspi_do_oe = do_en & ~qspi_csn;

endmodule
